// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that time-shares the core ALU,
// two ALU cycles per bit. Define MULDIV_DIV_EN to build the divide datapath.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_aluop,
    output logic [XLEN-1:0] alu_opr_a,
    output logic [XLEN-1:0] alu_opr_b,
    input  logic [XLEN-1:0] alu_opr_res
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [4:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_A = 2'd1,
        STEP_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // hi/lo double as rem/quo, mcand as divisor and sum as the shifted remainder.
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] sum_q, sum_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] finalVal;
`ifdef MULDIV_DIV_EN
    logic            ge_q, ge_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef MULDIV_DIV_EN
                        state_d = STEP_A;
`else
                        state_d = op[1] ? DONE : STEP_A;
`endif
                    end
                end
                STEP_A: state_d = STEP_B;
                STEP_B: state_d = (cnt_q == CNT_LAST) ? DONE : STEP_A;
                DONE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        finalVal = '0;
        unique case (op_q)
            2'b00: finalVal = lo_q;
            2'b01: finalVal = hi_q;
`ifdef MULDIV_DIV_EN
            2'b10: finalVal = lo_q;
            2'b11: finalVal = hi_q;
`endif
            default: finalVal = '0;
        endcase
    end

    // Result is shown live during DONE so it is valid with the done pulse; a kill
    // in DONE leaves the registered copy untouched.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE) && !kill;
        result    = done ? finalVal : result_q;
        alu_aluop = ALU_ADD;
        alu_opr_a = '0;
        alu_opr_b = '0;
        unique case (state_q)
            STEP_A: begin
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    alu_aluop = ALU_SLTU;
                    alu_opr_a = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                    alu_opr_b = mcand_q;
                end else
`endif
                begin
                    alu_aluop = ALU_ADD;
                    alu_opr_a = hi_q;
                    alu_opr_b = lo_q[0] ? mcand_q : '0;
                end
            end
            STEP_B: begin
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    alu_aluop = ALU_SUB;
                    alu_opr_a = sum_q;
                    alu_opr_b = mcand_q;
                end else
`endif
                begin
                    alu_aluop = ALU_SLTU;
                    alu_opr_a = sum_q;
                    alu_opr_b = hi_q;
                end
            end
            default: begin
                alu_aluop = ALU_ADD;
                alu_opr_a = '0;
                alu_opr_b = '0;
            end
        endcase
    end

    always_comb begin
        op_d     = op_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        ge_d     = ge_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d    = op;
                    mcand_d = rs2;
                    hi_d    = '0;
                    lo_d    = rs1;
                    cnt_d   = '0;
                end
            end
            STEP_A: begin
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    sum_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                    ge_d  = hi_q[XLEN-1] | ~alu_opr_res[0];
                end else
`endif
                begin
                    sum_d = alu_opr_res;
                end
            end
            STEP_B: begin
`ifdef MULDIV_DIV_EN
                if (op_q[1]) begin
                    hi_d = ge_q ? alu_opr_res : sum_q;
                    lo_d = {lo_q[XLEN-2:0], ge_q};
                end else
`endif
                begin
                    hi_d = {alu_opr_res[0], sum_q[XLEN-1:1]};
                    lo_d = {sum_q[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                if (!kill) begin
                    result_d = finalVal;
                end
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            ge_q     <= 1'b0;
`endif
        end else begin
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            ge_q     <= ge_d;
`endif
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural ALU; covers both MULDIV_DIV_EN builds.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  alu_aluop;
    logic [31:0] alu_opr_a;
    logic [31:0] alu_opr_b;
    logic [31:0] alu_opr_res;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .rs1(rs1),
        .rs2(rs2),
        .kill(kill),
        .busy(busy),
        .done(done),
        .result(result),
        .alu_aluop(alu_aluop),
        .alu_opr_a(alu_opr_a),
        .alu_opr_b(alu_opr_b),
        .alu_opr_res(alu_opr_res)
    );

    // Stand-in for the core's shared ALU.
    always_comb begin
        case (alu_aluop)
            4'b0000: alu_opr_res = alu_opr_a + alu_opr_b;
            4'b0001: alu_opr_res = alu_opr_a - alu_opr_b;
            4'b0100: alu_opr_res = {31'b0, (alu_opr_a < alu_opr_b)};
            default: alu_opr_res = 32'h0;
        endcase
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          expLat;
    } vec_t;

    vec_t vecs[$];
    int   vecCount;
    int   failCount;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expRes, input int expLat);
        vec_t v;
        v.name = name; v.op = o; v.a = a; v.b = b; v.expRes = expRes; v.expLat = expLat;
        vecs.push_back(v);
    endtask

    // Starts at a negedge, returns at the negedge of the done cycle (or after a timeout).
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat,
                                 output bit busyOk, output bit aluSeen);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busyOk = 1'b1; aluSeen = 1'b0;
        while (!done && lat < 200) begin
            if (!busy) busyOk = 1'b0;
            if (alu_aluop != 4'h0 || alu_opr_a != 32'h0 || alu_opr_b != 32'h0) aluSeen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!busy) busyOk = 1'b0;
        if (alu_aluop != 4'h0 || alu_opr_a != 32'h0 || alu_opr_b != 32'h0) aluSeen = 1'b1;
        res = result;
    endtask

    logic [31:0] res;
    logic [31:0] prevResult;
    int          lat;
    int          cyc;
    bit          busyOk;
    bit          aluSeen;
    bit          sawDone;

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; rs1 = 32'h0; rs2 = 32'h0;
        vecCount = 0; failCount = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset result", result, 32'h0);
        checkOutput("reset aluop", 32'(alu_aluop), 32'h0);
        checkOutput("reset opr_a", alu_opr_a, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        addVec("MUL 7x6",          2'b00, 32'd7,        32'd6,        32'h0000002A, 65);
        addVec("MUL ffx ff",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 65);
        addVec("MULHU ffxff",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 65);
        addVec("MUL 12345678x10",  2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 65);
        addVec("MULHU 12345678x10",2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 65);
        addVec("MULHU 8000_0000x2",2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 65);
        addVec("MUL 0x5",          2'b00, 32'h00000000, 32'h00000005, 32'h00000000, 65);
`ifdef MULDIV_DIV_EN
        addVec("DIVU 100/7",       2'b10, 32'd100,      32'd7,        32'h0000000E, 65);
        addVec("REMU 100/7",       2'b11, 32'd100,      32'd7,        32'h00000002, 65);
        addVec("DIVU 5/0",         2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 65);
        addVec("REMU 5/0",         2'b11, 32'd5,        32'd0,        32'h00000005, 65);
        addVec("DIVU ff/10",       2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 65);
        addVec("REMU ff/10",       2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 65);
        addVec("DIVU 8000/ffff",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 65);
        addVec("REMU 8000/ffff",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 65);
        addVec("DIVU ffff/8001",   2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 65);
        addVec("REMU ffff/8001",   2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 65);
`else
        addVec("DIVU off",         2'b10, 32'd100,      32'd7,        32'h00000000, 1);
        addVec("REMU off",         2'b11, 32'd5,        32'd0,        32'h00000000, 1);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busyOk, aluSeen);
            checkOutput({vecs[i].name, " result"}, res, vecs[i].expRes);
            checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].expLat));
            checkOutput({vecs[i].name, " busy held"}, 32'(busyOk), 32'h1);
            if (vecs[i].expLat == 1)
                checkOutput({vecs[i].name, " alu quiet"}, 32'(aluSeen), 32'h0);
            @(negedge clk);
            checkOutput({vecs[i].name, " idle busy"}, 32'(busy), 32'h0);
            checkOutput({vecs[i].name, " idle done"}, 32'(done), 32'h0);
            checkOutput({vecs[i].name, " held result"}, result, vecs[i].expRes);
        end

        // A second start while busy must not disturb the running operation.
        start = 1'b1; op = 2'b00; rs1 = 32'd7; rs2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == 10) begin
                start = 1'b1; op = 2'b01; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("restart ignored latency", 32'(cyc), 32'd65);
        checkOutput("restart ignored result", result, 32'h0000002A);
        @(negedge clk);
        checkOutput("b2b idle busy", 32'(busy), 32'h0);
        applyStimulus(2'b00, 32'd3, 32'd5, res, lat, busyOk, aluSeen);
        checkOutput("b2b latency", 32'(lat), 32'd65);
        checkOutput("b2b result", res, 32'd15);
        @(negedge clk);
        prevResult = 32'd15;

        // Kill mid-operation.
        start = 1'b1; op = 2'b00; rs1 = 32'hFFFFFFFF; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill busy", 32'(busy), 32'h0);
        checkOutput("kill aluop", 32'(alu_aluop), 32'h0);
        checkOutput("kill opr_a", alu_opr_a, 32'h0);
        checkOutput("kill result", result, prevResult);
        sawDone = 1'b0;
        repeat (80) begin
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("kill no done", 32'(sawDone), 32'h0);
        checkOutput("kill result kept", result, prevResult);

        // Reset mid-operation.
        start = 1'b1; op = 2'b01; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        #1;
        checkOutput("rst busy", 32'(busy), 32'h0);
        checkOutput("rst result", result, 32'h0);
        checkOutput("rst aluop", 32'(alu_aluop), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (80) begin
            if (done) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("rst no done", 32'(sawDone), 32'h0);
        prevResult = 32'h0;

        // Kill landing in the DONE cycle suppresses done and keeps the old result.
        start = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("killdone latency", 32'(cyc), 32'd65);
        kill = 1'b1;
        #1;
        checkOutput("killdone done", 32'(done), 32'h0);
        checkOutput("killdone result", result, prevResult);
        @(negedge clk);
        kill = 1'b0;
        checkOutput("killdone busy", 32'(busy), 32'h0);
        checkOutput("killdone result kept", result, prevResult);

        applyStimulus(2'b00, 32'd9, 32'd9, res, lat, busyOk, aluSeen);
        checkOutput("recover result", res, 32'd81);
        @(negedge clk);

        // Kill together with start in IDLE blocks acceptance.
        start = 1'b1; kill = 1'b1; op = 2'b00; rs1 = 32'd2; rs2 = 32'd2;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        checkOutput("kill blocks start", 32'(busy), 32'h0);
        checkOutput("kill blocks result", result, 32'd81);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
